// File: rtl/adc_pkg.sv
// adc_pkg: state encoding and counter sizing helpers shared
// by the serial ADC capture top and its SCLK generator.
package adc_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_QUIET
   } adc_state_e;

   localparam int DEF_DATA_W      = 12;
   localparam int DEF_LEAD_BITS   = 4;
   localparam int DEF_NUM_CH      = 2;
   localparam int DEF_CLK_DIV     = 5;
   localparam int DEF_QUIET_TICKS = 4;

   // Serial bits per frame: leading bits followed by data bits.
   function automatic int n_bits(input int lead, input int data);
      return lead + data;
   endfunction

   // Width of a counter holding n_vals distinct values (0..n_vals-1).
   function automatic int cnt_w(input int n_vals);
      return (n_vals <= 2) ? 1 : $clog2(n_vals);
   endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// adc_sclk_gen: system-clock divider producing a tick every CLK_DIV
// cycles and the ADC serial clock register (idles high).
// Ports: clk_i/rst_i sync reset; en_i runs divider; clr_i restarts it;
// toggle_i lets a tick flip SCLK; hold_i forces SCLK high;
// tick_o divider terminal count; sclk_o registered serial clock.
module adc_sclk_gen
   import adc_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic clr_i,
   input  logic toggle_i,
   input  logic hold_i,
   output logic tick_o,
   output logic sclk_o
);

   localparam int DIV_W = cnt_w(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             sclk_q, sclk_d;

   assign tick_o = en_i && (div_q == DIV_LAST);
   assign sclk_o = sclk_q;

   always_comb begin
      div_d = div_q + 1'b1;
      if (!en_i || clr_i || tick_o) begin
         div_d = '0;
      end
   end

   always_comb begin
      sclk_d = sclk_q;
      if (hold_i) begin
         sclk_d = 1'b1;
      end else if (toggle_i && tick_o) begin
         sclk_d = ~sclk_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q  <= '0;
         sclk_q <= 1'b1;
      end else begin
         div_q  <= div_d;
         sclk_q <= sclk_d;
      end
   end

endmodule

// File: rtl/adc_serial_capture.sv
// adc_serial_capture: drives CS/SCLK for NUM_CH simultaneous serial ADCs,
// shifts in LEAD_BITS+DATA_W bits per channel and publishes samples.
// Inputs: Clock_Nexys, Reset (sync high), start, continuous, data_ADC.
// Outputs: CS (low active), Clock_Muestreo (SCLK), busy, done pulse,
// Dato / data_basura (channel i at [i*W +: W]), lead_err.
module adc_serial_capture
   import adc_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int LEAD_BITS   = DEF_LEAD_BITS,
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int CLK_DIV     = DEF_CLK_DIV,
   parameter int QUIET_TICKS = DEF_QUIET_TICKS
) (
   input  logic                          Clock_Nexys,
   input  logic                          Reset,
   input  logic                          start,
   input  logic                          continuous,
   input  logic [NUM_CH-1:0]             data_ADC,
   output logic                          CS,
   output logic                          Clock_Muestreo,
   output logic                          busy,
   output logic                          done,
   output logic [NUM_CH*DATA_W-1:0]      Dato,
   output logic [NUM_CH*LEAD_BITS-1:0]   data_basura,
   output logic                          lead_err
);

   localparam int N_BITS = n_bits(LEAD_BITS, DATA_W);
   localparam int BIT_W  = cnt_w(N_BITS + 1);
   localparam int QT_W   = cnt_w(QUIET_TICKS);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_BITS);
   localparam logic [QT_W-1:0]  QT_LAST  = QT_W'(QUIET_TICKS - 1);

   adc_state_e                    state_q;
   logic [BIT_W-1:0]              bit_q;
   logic [QT_W-1:0]               qt_q;
   logic [NUM_CH-1:0][N_BITS-1:0] sh_q;
   logic                          cs_q;
   logic                          busy_q;
   logic                          done_q;
   logic                          err_q;
   logic [NUM_CH*DATA_W-1:0]      dato_q;
   logic [NUM_CH*LEAD_BITS-1:0]   lead_q;

   logic tick;
   logic sclk;
   logic go;
   logic in_idle;
   logic in_conv;
   logic in_quiet;
   logic rise;
   logic frame_end;
   logic quiet_end;
   logic div_clr;
   logic sclk_toggle;

   logic [NUM_CH*DATA_W-1:0]    cap_dato;
   logic [NUM_CH*LEAD_BITS-1:0] cap_lead;

   assign go       = start | continuous;
   assign in_idle  = (state_q == S_IDLE);
   assign in_conv  = (state_q == S_CONV);
   assign in_quiet = (state_q == S_QUIET);

   // SCLK high on a tick: falls unless all N bits are in,
   // in which case that tick closes the frame instead.
   assign rise      = in_conv && tick && !sclk;
   assign frame_end = in_conv && tick && sclk && (bit_q == BIT_LAST);
   assign quiet_end = in_quiet && tick && (qt_q == QT_LAST);

   assign div_clr     = frame_end | quiet_end | (in_idle & go);
   assign sclk_toggle = in_conv && !(sclk && (bit_q == BIT_LAST));

   adc_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk (
      .clk_i    (Clock_Nexys),
      .rst_i    (Reset),
      .en_i     (!in_idle),
      .clr_i    (div_clr),
      .toggle_i (sclk_toggle),
      .hold_i   (!in_conv),
      .tick_o   (tick),
      .sclk_o   (sclk)
   );

   // Split each channel's frame into leading and data fields.
   always_comb begin
      cap_dato = '0;
      cap_lead = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         cap_dato[c*DATA_W +: DATA_W]       = sh_q[c][DATA_W-1:0];
         cap_lead[c*LEAD_BITS +: LEAD_BITS] = sh_q[c][N_BITS-1:DATA_W];
      end
   end

   always_ff @(posedge Clock_Nexys) begin
      if (Reset) begin
         state_q <= S_IDLE;
         bit_q   <= '0;
         qt_q    <= '0;
         sh_q    <= '0;
         cs_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         dato_q  <= '0;
         lead_q  <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (go) begin
                  state_q <= S_CONV;
                  cs_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  bit_q   <= '0;
               end
            end
            S_CONV: begin
               if (rise && (bit_q != BIT_LAST)) begin
                  bit_q <= bit_q + 1'b1;
                  for (int c = 0; c < NUM_CH; c++) begin
                     sh_q[c] <= {sh_q[c][N_BITS-2:0], data_ADC[c]};
                  end
               end
               if (frame_end) begin
                  state_q <= S_QUIET;
                  cs_q    <= 1'b1;
                  qt_q    <= '0;
                  done_q  <= 1'b1;
                  dato_q  <= cap_dato;
                  lead_q  <= cap_lead;
                  err_q   <= |cap_lead;
               end
            end
            S_QUIET: begin
               if (quiet_end) begin
                  if (go) begin
                     state_q <= S_CONV;
                     cs_q    <= 1'b0;
                     bit_q   <= '0;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else if (tick) begin
                  qt_q <= qt_q + 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               cs_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign CS             = cs_q;
   assign Clock_Muestreo = sclk;
   assign busy           = busy_q;
   assign done           = done_q;
   assign Dato           = dato_q;
   assign data_basura    = lead_q;
   assign lead_err       = err_q;

endmodule

// File: tb/tb_adc_serial_capture.sv
// tb_adc_serial_capture: ADC behavioural model plus frame scoreboard
// exercising single, continuous, error and reset-abort scenarios.
module tb_adc_serial_capture;

   localparam int DW = 12;
   localparam int LB = 4;
   localparam int NC = 2;
   localparam int CD = 2;
   localparam int QT = 4;
   localparam int N  = LB + DW;
   localparam int CS_LOW = (2 * N + 1) * CD;
   localparam int GAP    = CS_LOW + QT * CD;

   logic              clk = 1'b0;
   logic              Reset = 1'b1;
   logic              start = 1'b0;
   logic              continuous = 1'b0;
   logic [NC-1:0]     data_ADC = '0;
   logic              CS;
   logic              Clock_Muestreo;
   logic              busy;
   logic              done;
   logic [NC*DW-1:0]  Dato;
   logic [NC*LB-1:0]  data_basura;
   logic              lead_err;

   int checks = 0;
   int errors = 0;

   adc_serial_capture #(
      .DATA_W      (DW),
      .LEAD_BITS   (LB),
      .NUM_CH      (NC),
      .CLK_DIV     (CD),
      .QUIET_TICKS (QT)
   ) dut (
      .Clock_Nexys    (clk),
      .Reset          (Reset),
      .start          (start),
      .continuous     (continuous),
      .data_ADC       (data_ADC),
      .CS             (CS),
      .Clock_Muestreo (Clock_Muestreo),
      .busy           (busy),
      .done           (done),
      .Dato           (Dato),
      .data_basura    (data_basura),
      .lead_err       (lead_err)
   );

   always #5 clk = ~clk;

   // ADC model: each frame is N bits per channel, MSB first,
   // with the next bit presented on every SCLK fall while CS is low.
   logic [NC*N-1:0] fq[$];
   logic [NC*N-1:0] cur = '0;
   int              idx = 0;

   always @(negedge Clock_Muestreo or posedge CS) begin
      if (CS) begin
         idx = 0;
      end else if (idx < N) begin
         if (idx == 0) cur = (fq.size() > 0) ? fq.pop_front() : '0;
         for (int c = 0; c < NC; c++) data_ADC[c] = cur[c*N + N-1-idx];
         idx++;
      end
   end

   function automatic logic [NC*N-1:0] mk(input logic [LB-1:0] l0,
                                          input logic [DW-1:0] d0,
                                          input logic [LB-1:0] l1,
                                          input logic [DW-1:0] d1);
      return {l1, d1, l0, d0};
   endfunction

   function automatic logic [NC*DW-1:0] exp_dato(input logic [NC*N-1:0] f);
      logic [NC*DW-1:0] r;
      r = '0;
      for (int c = 0; c < NC; c++)
         r[c*DW +: DW] = DW'(int'(f[c*N +: N]) % (2 ** DW));
      return r;
   endfunction

   function automatic logic [NC*LB-1:0] exp_lead(input logic [NC*N-1:0] f);
      logic [NC*LB-1:0] r;
      r = '0;
      for (int c = 0; c < NC; c++)
         r[c*LB +: LB] = LB'(int'(f[c*N +: N]) / (2 ** DW));
      return r;
   endfunction

   // Start one frame and wait (bounded) until done; reports CS-low cycles.
   task automatic run_frame(input logic [NC*N-1:0] f,
                            output int cs_low, output bit ok);
      fq.push_back(f);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cs_low = 0;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (!CS) cs_low++;
         @(negedge clk);
      end
   endtask

   // Advance n cycles, counting done pulses seen.
   task automatic idle_cycles(input int n, output int dones);
      dones = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({CS, Clock_Muestreo, busy, done, lead_err} !== 5'b11000) begin
         errors++;
         $display("FAIL reset_ctl got %b want 11000",
                  {CS, Clock_Muestreo, busy, done, lead_err});
      end
      checks++;
      if (Dato !== '0 || data_basura !== '0) begin
         errors++;
         $display("FAIL reset_data got %h/%h want 0/0", Dato, data_basura);
      end
      Reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic frame_check(input string nm, input logic [NC*N-1:0] f,
                              input bit chk_len);
      int  cs_low, dn;
      bit  ok;
      run_frame(f, cs_low, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_timeout got no done want done", nm);
      end
      if (chk_len) begin
         checks++;
         if (cs_low != CS_LOW) begin
            errors++;
            $display("FAIL %s_cs_low got %0d want %0d", nm, cs_low, CS_LOW);
         end
      end
      checks++;
      if (Dato !== exp_dato(f) || data_basura !== exp_lead(f) ||
          lead_err !== (exp_lead(f) != 0)) begin
         errors++;
         $display("FAIL %s_data got %h/%h/%b want %h/%h/%b", nm, Dato,
                  data_basura, lead_err, exp_dato(f), exp_lead(f),
                  exp_lead(f) != 0);
      end
      idle_cycles(QT * CD + 2, dn);
      checks++;
      if (dn != 0 || busy !== 1'b0 || CS !== 1'b1) begin
         errors++;
         $display("FAIL %s_idle got dones=%0d busy=%b cs=%b want 0/0/1",
                  nm, dn, busy, CS);
      end
   endtask

   task automatic test_pattern();
      frame_check("pattern", mk(4'h0, 12'hAAA, 4'h0, 12'h555), 1'b1);
   endtask

   task automatic test_swapped();
      frame_check("swapped", mk(4'h0, 12'h555, 4'h0, 12'hAAA), 1'b1);
   endtask

   task automatic test_random();
      for (int k = 0; k < 4; k++) begin
         logic [LB-1:0] l0, l1;
         l0 = ($urandom_range(0, 3) == 0) ? LB'($urandom) : '0;
         l1 = ($urandom_range(0, 3) == 0) ? LB'($urandom) : '0;
         frame_check("random", mk(l0, DW'($urandom), l1, DW'($urandom)),
                     1'b1);
      end
   endtask

   task automatic test_continuous();
      logic [NC*N-1:0] f[3];
      int gap, busy_lo;
      for (int k = 0; k < 3; k++) begin
         f[k] = mk('0, DW'(k + 1), '0, DW'(k + 1));
         fq.push_back(f[k]);
      end
      busy_lo = 0;
      continuous = 1'b1;
      for (int k = 0; k < 3; k++) begin
         gap = 0;
         do begin
            @(negedge clk);
            gap++;
            if (k > 0 && !busy) busy_lo++;
         end while (!done && gap < 2000);
         if (k == 2) continuous = 1'b0;
         if (k > 0) begin
            checks++;
            if (gap != GAP) begin
               errors++;
               $display("FAIL cont_gap%0d got %0d want %0d", k, gap, GAP);
            end
         end
         checks++;
         if (Dato !== exp_dato(f[k])) begin
            errors++;
            $display("FAIL cont_data%0d got %h want %h", k, Dato,
                     exp_dato(f[k]));
         end
      end
      checks++;
      if (busy_lo != 0) begin
         errors++;
         $display("FAIL cont_busy got %0d idle cycles want 0", busy_lo);
      end
      idle_cycles(QT * CD + 2, gap);
      checks++;
      if (gap != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL cont_stop got dones=%0d busy=%b want 0/0", gap, busy);
      end
   endtask

   task automatic test_lead_err();
      frame_check("leaderr", mk(4'h0, 12'h3C5, 4'h4, 12'hFFF), 1'b0);
      checks++;
      if (data_basura[LB +: LB] !== 4'h4 || lead_err !== 1'b1) begin
         errors++;
         $display("FAIL leaderr_flag got %h/%b want 4/1",
                  data_basura[LB +: LB], lead_err);
      end
      frame_check("clean", mk(4'h0, 12'h5A5, 4'h0, 12'h0F1), 1'b0);
      checks++;
      if (lead_err !== 1'b0) begin
         errors++;
         $display("FAIL clean_flag got %b want 0", lead_err);
      end
   endtask

   task automatic test_reset_mid();
      int  rises, dn;
      bit  prev;
      fq.push_back(mk(4'h0, 12'h123, 4'h0, 12'h456));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rises = 0;
      prev = Clock_Muestreo;
      for (int i = 0; i < 500 && rises < 7; i++) begin
         @(negedge clk);
         if (!prev && Clock_Muestreo) rises++;
         prev = Clock_Muestreo;
      end
      checks++;
      if (rises != 7) begin
         errors++;
         $display("FAIL rstmid_rises got %0d want 7", rises);
      end
      Reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({CS, Clock_Muestreo, busy, done} !== 4'b1100 || Dato !== '0) begin
         errors++;
         $display("FAIL rstmid_state got %b/%h want 1100/0",
                  {CS, Clock_Muestreo, busy, done}, Dato);
      end
      Reset = 1'b0;
      idle_cycles(CS_LOW + 10, dn);
      checks++;
      if (dn != 0 || CS !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_nodone got dones=%0d cs=%b want 0/1", dn, CS);
      end
      frame_check("fresh", mk(4'h0, 12'h9C3, 4'h0, 12'h0E7), 1'b1);
   endtask

   task automatic test_start_toggle();
      logic [NC*N-1:0] f;
      int dn;
      f = mk('0, DW'($urandom), '0, DW'($urandom));
      fq.push_back(f);
      start = 1'b1;
      @(negedge clk);
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         start = 1'($urandom);
         @(negedge clk);
         if (done) dn++;
      end
      start = 1'b0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (done) begin
            dn++;
            checks++;
            if (Dato !== exp_dato(f)) begin
               errors++;
               $display("FAIL toggle_data got %h want %h", Dato, exp_dato(f));
            end
         end
      end
      checks++;
      if (dn != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL toggle_dones got %0d busy=%b want 1/0", dn, busy);
      end
   endtask

   initial begin
      test_reset();
      test_pattern();
      test_swapped();
      test_random();
      test_continuous();
      test_lead_err();
      test_reset_mid();
      test_start_toggle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
